// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package wb_arbiter_pkg;

    localparam int   AW_DEFAULT    = 5;
    localparam int   DW_DEFAULT    = 32;
    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Source chosen for the output register at each edge.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_A    = 2'd1,
        SEL_HEAD = 2'd2,
        SEL_B    = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// Port-B result queue. Every entry carries a live bit, so a younger ALU write
// can cancel a queued result in place instead of having to remove it.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [AW-1:0]    i_push_addr,
    input  logic [DW-1:0]    i_push_data,
    input  logic             i_pop,
    input  logic             i_kill,
    input  logic [AW-1:0]    i_kill_addr,
    input  logic [AW-1:0]    i_match_addr,
    output logic             o_match,
    output logic             o_head_live,
    output logic [AW-1:0]    o_head_addr,
    output logic [DW-1:0]    o_head_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_any_live
);

    logic             r_live [DEPTH];
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_match;
    logic             w_any_live;

    // Pointers, occupancy and live bits; kill lands before pop/push so a new push wins its slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == RST_ENABLE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_live[i] <= 1'b0;
            end
        end else begin
            if (i_kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_live[i] && (r_addr[i] == i_kill_addr)) begin
                        r_live[i] <= 1'b0;
                    end
                end
            end
            if (i_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push) begin
                r_live[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; the live bits qualify it.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_push_addr;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    // Address lookup and occupancy summary over live entries only.
    always_comb begin
        w_match    = 1'b0;
        w_any_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) begin
                w_any_live = 1'b1;
                if (r_addr[i] == i_match_addr) begin
                    w_match = 1'b1;
                end
            end
        end
    end

    assign o_match     = w_match;
    assign o_any_live  = w_any_live;
    assign o_head_live = r_live[r_rd_ptr];
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Drives the single regfile write port from the ALU (port A, never stalls,
// always wins) and the load/divide units (port B, queued on conflict).
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [AW-1:0] a_waddr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_waddr,
    input  logic [DW-1:0] b_wdata,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          pending,
    input  logic [AW-1:0] q_raddr,
    output logic          q_hit
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             w_a_wr;
    logic             w_b_acc;
    logic             w_b_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_match;
    logic             w_head_live;
    logic [AW-1:0]    w_head_addr;
    logic [DW-1:0]    w_head_data;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_any_live;
    wb_sel_e          w_sel;

    logic             r_we;
    logic [AW-1:0]    r_waddr;
    logic [DW-1:0]    r_wdata;

    assign b_ready = (rst != RST_ENABLE) && (w_count < CNT_W'(DEPTH));
    assign w_a_wr  = a_valid && (a_waddr != '0);
    assign w_b_acc = b_valid && b_ready;
    // A same-address ALU write is younger, so the B result would be overwritten anyway.
    assign w_b_ok  = w_b_acc && (b_waddr != '0) && !(w_a_wr && (b_waddr == a_waddr));

    // Pick the output source; a dead head is discarded regardless of A.
    always_comb begin
        w_sel  = SEL_NONE;
        w_pop  = 1'b0;
        w_push = 1'b0;
        if (w_a_wr) begin
            w_sel = SEL_A;
            w_pop = !w_empty && !w_head_live;
        end else if (!w_empty) begin
            w_pop = 1'b1;
            if (w_head_live) begin
                w_sel = SEL_HEAD;
            end
        end else if (w_b_ok) begin
            w_sel = SEL_B;
        end
        if (w_b_ok && (w_sel != SEL_B)) begin
            w_push = 1'b1;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_push       (w_push),
        .i_push_addr  (b_waddr),
        .i_push_data  (b_wdata),
        .i_pop        (w_pop),
        .i_kill       (w_a_wr),
        .i_kill_addr  (a_waddr),
        .i_match_addr (q_raddr),
        .o_match      (w_match),
        .o_head_live  (w_head_live),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_empty      (w_empty),
        .o_count      (w_count),
        .o_any_live   (w_any_live)
    );

    // Registered write port; address and data hold while no write is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_we    <= WRITE_DISABLE;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            unique case (w_sel)
                SEL_A: begin
                    r_we    <= WRITE_ENABLE;
                    r_waddr <= a_waddr;
                    r_wdata <= a_wdata;
                end
                SEL_HEAD: begin
                    r_we    <= WRITE_ENABLE;
                    r_waddr <= w_head_addr;
                    r_wdata <= w_head_data;
                end
                SEL_B: begin
                    r_we    <= WRITE_ENABLE;
                    r_waddr <= b_waddr;
                    r_wdata <= b_wdata;
                end
                default: begin
                    r_we <= WRITE_DISABLE;
                end
            endcase
        end
    end

    assign we      = r_we;
    assign waddr   = r_waddr;
    assign wdata   = r_wdata;
    assign pending = w_any_live;
    assign q_hit   = (q_raddr != '0) && w_match;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, compared
// against a queue-based model of the write-back rules.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid;
    logic [AW-1:0] a_waddr;
    logic [DW-1:0] a_wdata;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_waddr;
    logic [DW-1:0] b_wdata;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          pending;
    logic [AW-1:0] q_raddr;
    logic          q_hit;

    wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_waddr (a_waddr),
        .a_wdata (a_wdata),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_waddr (b_waddr),
        .b_wdata (b_wdata),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .pending (pending),
        .q_raddr (q_raddr),
        .q_hit   (q_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    logic          exp_we;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    int            n_chk  = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_pending();
        foreach (mq[i]) if (mq[i].live) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_hit(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Apply the write-back rules to the model queue for one rising edge.
    task automatic model_edge();
        bit   a_wr, b_ok, was_empty;
        ent_t h;
        a_wr      = a_valid && (a_waddr != '0);
        b_ok      = b_valid && (mq.size() < DEPTH) && (b_waddr != '0) &&
                    !(a_wr && (b_waddr == a_waddr));
        was_empty = (mq.size() == 0);
        if (a_wr) begin
            exp_we = 1'b1; exp_waddr = a_waddr; exp_wdata = a_wdata;
            if (!was_empty && !mq[0].live) void'(mq.pop_front());
        end else if (!was_empty) begin
            h      = mq.pop_front();
            exp_we = h.live;
            if (h.live) begin
                exp_waddr = h.addr; exp_wdata = h.data;
            end
        end else if (b_ok) begin
            exp_we = 1'b1; exp_waddr = b_waddr; exp_wdata = b_wdata;
        end else begin
            exp_we = 1'b0;
        end
        if (a_wr) begin
            foreach (mq[i]) if (mq[i].addr == a_waddr) mq[i].live = 1'b0;
        end
        if (b_ok && !(!a_wr && was_empty)) begin
            mq.push_back('{live: 1'b1, addr: b_waddr, data: b_wdata});
        end
    endtask

    // One clock: check combinational outputs, take the edge, check registers.
    task automatic step();
        #1;
        chk("b_ready", b_ready, (mq.size() < DEPTH));
        chk("pending", pending, m_pending());
        chk("q_hit",   q_hit,   m_hit(q_raddr));
        @(posedge clk);
        model_edge();
        #1;
        chk("we",    we,    exp_we);
        chk("waddr", waddr, exp_waddr);
        chk("wdata", wdata, exp_wdata);
        chk("nop_write", (we && waddr == '0), 1'b0);
        @(negedge clk);
    endtask

    task automatic cyc(input bit av, input int aa, input int ad,
                       input bit bv, input int ba, input int bd, input int qr);
        a_valid = av; a_waddr = AW'(aa); a_wdata = DW'(ad);
        b_valid = bv; b_waddr = AW'(ba); b_wdata = DW'(bd);
        q_raddr = AW'(qr);
        step();
    endtask

    task automatic idle(input int n, input int qr);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, qr);
    endtask

    initial begin
        rst = 1'b0;
        a_valid = 0; a_waddr = '0; a_wdata = '0;
        b_valid = 0; b_waddr = '0; b_wdata = '0; q_raddr = '0;
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
        repeat (2) @(negedge clk);
        b_valid = 1'b1;
        #1;
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_we",      we,      1'b0);
        chk("rst_waddr",   waddr,   '0);
        chk("rst_wdata",   wdata,   '0);
        chk("rst_pending", pending, 1'b0);
        b_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // ALU only
        cyc(1, 3, 'h11, 0, 0, 0, 0);
        idle(1, 0);
        // B bypass
        cyc(0, 0, 0, 1, 4, 'h22, 4);
        idle(1, 0);
        // Conflict: A wins, B queued one cycle
        cyc(1, 3, 'hA, 1, 4, 'hB, 4);
        idle(2, 4);
        // Kill: queued (5,0x55) overwritten by younger A to 5
        cyc(1, 1, 1, 1, 5, 'h55, 5);
        cyc(1, 2, 2, 0, 0, 0, 5);
        cyc(1, 5, 'h66, 0, 0, 0, 5);
        idle(3, 5);
        // Same-cycle same-address: B dropped
        cyc(1, 6, 'h77, 1, 6, 'h88, 6);
        idle(2, 6);
        // Full FIFO then drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 1, 8 + i, 'h100 + i, 9);
        cyc(1, 1, 9, 1, 20, 'h999, 20);
        idle(DEPTH + 2, 10);
        // Address-0 writes on both ports
        cyc(1, 0, 'hDEAD, 1, 0, 'hBEEF, 0);
        idle(2, 0);

        // Reset mid-stream with three queued entries
        for (int i = 0; i < 3; i++) cyc(1, 1, 'h40 + i, 1, 12 + i, 'h200 + i, 13);
        a_valid = 0; b_valid = 0; q_raddr = AW'(13);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_we",      we,      1'b0);
        chk("mid_rst_pending", pending, 1'b0);
        chk("mid_rst_q_hit",   q_hit,   1'b0);
        chk("mid_rst_b_ready", b_ready, 1'b0);
        mq.delete();
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(4, 13);
        cyc(0, 0, 0, 1, 7, 'h300, 7);
        idle(1, 0);

        // Random traffic: ALU-heavy (fills queue), balanced, ALU-light (drains)
        for (int ph = 0; ph < 3; ph++) begin
            int pa;
            pa = (ph == 0) ? 90 : (ph == 1) ? 50 : 15;
            for (int i = 0; i < 300; i++) begin
                cyc(($urandom_range(0, 99) < pa), $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 7));
            end
        end
        idle(DEPTH + 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
